buck_interleave_pwm: RTL and testbench

Two-phase interleaved buck PWM generator for the discharge power stage. Owns the 4 µs switching timebase, exporting the phase-0 and phase-1 period counters that the upstream one-cycle controller uses to sample current and to time its duty computation. Consumes that controller's per-period `inductor_charging_time`, latches it once per phase per period, and drives high-side/low-side gates with dead time. Adds enable sequencing and a latched fault shutdown.

---
 rtl/buck_interleave_pwm.sv | 172 +++++++++++++++++
 tb/tb_buck_interleave_pwm.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/buck_interleave_pwm.sv
// buck_interleave_pwm
// Two-phase interleaved buck PWM generator with a free-running switching
// timebase, per-phase duty latching, dead-time gate drive, enable sequencing
// and a latched fault shutdown.
//
// Ports:
//   clk                    in   system clock (100 MHz)
//   rst                    in   synchronous active-high reset
//   enable                 in   run request (level)
//   fault                  in   over-current / gap-short fault (level)
//   fault_clr              in   fault acknowledge (level)
//   inductor_charging_time in   requested high-side on-time in clk cycles
//   timer_buck_4us_0       out  phase-0 period counter, 0..PERIOD-1
//   timer_buck_interleave  out  phase-1 period counter (phase 0 + PHASE_OFFSET)
//   period_start           out  pulse while phase-0 counter is 0
//   hs_gate / ls_gate      out  high-/low-side gates, bit k = phase k
//   run                    out  high in RUN
//   fault_latched          out  high in FAULT
module buck_interleave_pwm #(
    parameter int PERIOD       = 400,
    parameter int PHASE_OFFSET = 200,
    parameter int MAX_ON       = 200,
    parameter int MIN_ON       = 8,
    parameter int DEADTIME     = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        fault,
    input  logic        fault_clr,
    input  logic [15:0] inductor_charging_time,
    output logic [15:0] timer_buck_4us_0,
    output logic [15:0] timer_buck_interleave,
    output logic        period_start,
    output logic [1:0]  hs_gate,
    output logic [1:0]  ls_gate,
    output logic        run,
    output logic        fault_latched
);

    localparam logic [15:0] CNT_LAST = 16'(PERIOD - 1);
    localparam logic [15:0] LS_END   = 16'(PERIOD - DEADTIME);
    localparam logic [16:0] DT_W     = 17'(DEADTIME);
    localparam logic [15:0] MAX_ON_W = 16'(MAX_ON);
    localparam logic [15:0] MIN_ON_W = 16'(MIN_ON);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   period_start_q, period_start_d;
    logic   latch_edge0;

    // Requested on-time limited to the ceiling; slivers too short to be
    // useful are dropped entirely rather than rounded up.
    function automatic logic [15:0] clamp_on(input logic [15:0] v);
        if (v > MAX_ON_W) begin
            return MAX_ON_W;
        end else if ((v != 16'd0) && (v < MIN_ON_W)) begin
            return 16'd0;
        end else begin
            return v;
        end
    endfunction

    // IDLE->RUN waits for the last phase-0 count so switching always begins
    // on a phase-0 period boundary.
    assign latch_edge0 = (timer_buck_4us_0 == CNT_LAST);

    always_comb begin
        state_d = state_q;
        if (fault) begin
            state_d = ST_FAULT;
        end else begin
            unique case (state_q)
                ST_IDLE:  if (enable && latch_edge0) state_d = ST_RUN;
                ST_RUN:   if (!enable) state_d = ST_IDLE;
                ST_FAULT: if (fault_clr) state_d = ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Per-phase timebase, duty latch and gate drive. Each phase owns an
    // independent counter so the exported timers never depend on state.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : ph
            localparam logic [15:0] CNT_RST = 16'(gi * PHASE_OFFSET);

            logic [15:0] cnt_q, cnt_d;
            logic [15:0] duty_q, duty_d;
            logic        act_q, act_d;
            logic        hs_q, hs_d;
            logic        ls_q, ls_d;
            logic        latch_edge;
            logic        switching;

            assign latch_edge = (cnt_q == CNT_LAST);

            // Gates use the next state so enable/fault removal reaches the
            // gates one cycle after it is sampled. act_q keeps a phase dark
            // until it has latched its first duty after entering RUN.
            assign switching = (state_d == ST_RUN) && act_q;

            always_comb begin
                cnt_d  = latch_edge ? 16'd0 : cnt_q + 16'd1;
                duty_d = duty_q;
                act_d  = act_q;
                hs_d   = switching && (cnt_q < duty_q);
                ls_d   = switching
                         && ({1'b0, cnt_q} >= ({1'b0, duty_q} + DT_W))
                         && (cnt_q < LS_END);
                if (state_d != ST_RUN) begin
                    duty_d = 16'd0;
                    act_d  = 1'b0;
                end else if (latch_edge) begin
                    duty_d = clamp_on(inductor_charging_time);
                    act_d  = 1'b1;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt_q  <= CNT_RST;
                    duty_q <= 16'd0;
                    act_q  <= 1'b0;
                    hs_q   <= 1'b0;
                    ls_q   <= 1'b0;
                end else begin
                    cnt_q  <= cnt_d;
                    duty_q <= duty_d;
                    act_q  <= act_d;
                    hs_q   <= hs_d;
                    ls_q   <= ls_d;
                end
            end

            assign hs_gate[gi] = hs_q;
            assign ls_gate[gi] = ls_q;
        end
    endgenerate

    // Registered so the pulse is coincident with the counter reading 0.
    assign period_start_d = (ph[0].cnt_d == 16'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            period_start_q <= 1'b1;
        end else begin
            period_start_q <= period_start_d;
        end
    end

    assign timer_buck_4us_0      = ph[0].cnt_q;
    assign timer_buck_interleave = ph[1].cnt_q;
    assign period_start          = period_start_q;
    assign run                   = (state_q == ST_RUN);
    assign fault_latched         = (state_q == ST_FAULT);

endmodule

// File: tb/tb_buck_interleave_pwm.sv
// Self-checking bench for buck_interleave_pwm: directed scenarios plus a
// randomized phase, every cycle compared against a behavioural model.
module tb_buck_interleave_pwm;

    localparam int P     = 400;
    localparam int OFF   = 200;
    localparam int MAXON = 200;
    localparam int MINON = 8;
    localparam int DT    = 10;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        fault;
    logic        fault_clr;
    logic [15:0] ict;
    logic [15:0] timer_buck_4us_0;
    logic [15:0] timer_buck_interleave;
    logic        period_start;
    logic [1:0]  hs_gate;
    logic [1:0]  ls_gate;
    logic        run;
    logic        fault_latched;

    buck_interleave_pwm dut (
        .clk                    (clk),
        .rst                    (rst),
        .enable                 (enable),
        .fault                  (fault),
        .fault_clr              (fault_clr),
        .inductor_charging_time (ict),
        .timer_buck_4us_0       (timer_buck_4us_0),
        .timer_buck_interleave  (timer_buck_interleave),
        .period_start           (period_start),
        .hs_gate                (hs_gate),
        .ls_gate                (ls_gate),
        .run                    (run),
        .fault_latched          (fault_latched)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;

    // Behavioural model: time since reset, mode and per-phase duty.
    int m_n;
    int m_state;          // 0 idle, 1 run, 2 fault
    int m_duty [2];
    bit m_act  [2];
    bit m_hs   [2];
    bit m_ls   [2];
    bit m_ps;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic int clamp_on(input int v);
        if (v > MAXON) return MAXON;
        if (v > 0 && v < MINON) return 0;
        return v;
    endfunction

    task automatic model_edge();
        int c [2];
        int ns;
        if (rst) begin
            m_n = 0; m_state = 0; m_ps = 1'b1;
            for (int k = 0; k < 2; k++) begin
                m_duty[k] = 0; m_act[k] = 1'b0; m_hs[k] = 1'b0; m_ls[k] = 1'b0;
            end
            return;
        end
        c[0] = m_n % P;
        c[1] = (m_n + OFF) % P;
        if (fault) ns = 2;
        else if (m_state == 0) ns = (enable && c[0] == P - 1) ? 1 : 0;
        else if (m_state == 1) ns = enable ? 1 : 0;
        else ns = fault_clr ? 0 : 2;
        for (int k = 0; k < 2; k++) begin
            m_hs[k] = (ns == 1) && m_act[k] && (c[k] < m_duty[k]);
            m_ls[k] = (ns == 1) && m_act[k] && (c[k] >= m_duty[k] + DT) && (c[k] < P - DT);
            if (ns != 1) begin
                m_duty[k] = 0; m_act[k] = 1'b0;
            end else if (c[k] == P - 1) begin
                m_duty[k] = clamp_on(int'(ict)); m_act[k] = 1'b1;
            end
        end
        m_state = ns;
        m_n++;
        m_ps = (m_n % P) == 0;
    endtask

    task automatic compare();
        check_eq("timer0", 32'(timer_buck_4us_0), 32'(m_n % P));
        check_eq("timer1", 32'(timer_buck_interleave), 32'((m_n + OFF) % P));
        check_eq("period_start", 32'(period_start), 32'(m_ps));
        check_eq("hs_gate", 32'(hs_gate), 32'({m_hs[1], m_hs[0]}));
        check_eq("ls_gate", 32'(ls_gate), 32'({m_ls[1], m_ls[0]}));
        check_eq("run", 32'(run), 32'(m_state == 1));
        check_eq("fault_latched", 32'(fault_latched), 32'(m_state == 2));
        check_eq("hs_ls_overlap", 32'(hs_gate & ls_gate), 32'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare();
    endtask

    task automatic window(output int hs0, output int ls0, output int hs1, output int ls1);
        hs0 = 0; ls0 = 0; hs1 = 0; ls1 = 0;
        for (int i = 0; i < P; i++) begin
            tick();
            hs0 += int'(hs_gate[0]); ls0 += int'(ls_gate[0]);
            hs1 += int'(hs_gate[1]); ls1 += int'(ls_gate[1]);
        end
    endtask

    // Bounded wait until the phase-0 count reaches a target.
    task automatic wait_c0(input int target);
        int i;
        for (i = 0; i < 2 * P && (m_n % P) != target; i++) tick();
        check_eq("wait_c0_reached", 32'(m_n % P), 32'(target));
    endtask

    int hs0, ls0, hs1, ls1, ps_cnt;
    int vals [6] = '{300, 5, 8, 0, 7, 200};

    initial begin
        rst = 1'b1; enable = 1'b0; fault = 1'b0; fault_clr = 1'b0; ict = 16'd0;
        repeat (5) tick();
        rst = 1'b0;
        check_eq("rst_timer0", 32'(timer_buck_4us_0), 32'd0);
        check_eq("rst_timer1", 32'(timer_buck_interleave), 32'(OFF));
        check_eq("rst_gates", 32'({hs_gate, ls_gate}), 32'd0);

        ps_cnt = int'(period_start);
        for (int i = 0; i < P; i++) begin
            tick();
            ps_cnt += int'(period_start);
        end
        check_eq("period_start_count", 32'(ps_cnt), 32'd2);

        // Steady duty 100.
        enable = 1'b1; ict = 16'd100;
        repeat (2 * P) tick();
        window(hs0, ls0, hs1, ls1);
        check_eq("d100_hs0", 32'(hs0), 32'd100);
        check_eq("d100_ls0", 32'(ls0), 32'd280);
        check_eq("d100_hs1", 32'(hs1), 32'd100);
        check_eq("d100_ls1", 32'(ls1), 32'd280);

        // Clamp cases and a few boundary values.
        foreach (vals[j]) begin
            ict = 16'(vals[j]);
            repeat (2 * P) tick();
            window(hs0, ls0, hs1, ls1);
            check_eq("clamp_hs0", 32'(hs0), 32'(clamp_on(vals[j])));
            check_eq("clamp_ls0", 32'(ls0), 32'(P - DT - (clamp_on(vals[j]) + DT)));
            check_eq("clamp_hs1", 32'(hs1), 32'(clamp_on(vals[j])));
        end

        // Latch timing: change mid-pulse only affects the next period.
        ict = 16'd100;
        repeat (2 * P) tick();
        wait_c0(30);
        ict = 16'd50;
        wait_c0(P - 1);
        tick();
        window(hs0, ls0, hs1, ls1);
        check_eq("latch_next_hs0", 32'(hs0), 32'd50);

        // Fault mid-pulse, clear ignored while fault high, then re-arm.
        ict = 16'd100;
        repeat (2 * P) tick();
        wait_c0(40);
        fault = 1'b1;
        tick();
        check_eq("fault_gates_off", 32'({hs_gate, ls_gate}), 32'd0);
        check_eq("fault_latched_set", 32'(fault_latched), 32'd1);
        fault_clr = 1'b1;
        repeat (5) tick();
        check_eq("fault_clr_ignored", 32'(fault_latched), 32'd1);
        fault = 1'b0;
        tick();
        check_eq("fault_cleared", 32'(fault_latched), 32'd0);
        check_eq("fault_to_idle_run", 32'(run), 32'd0);
        fault_clr = 1'b0;
        repeat (2 * P) tick();

        // Enable drop mid-pulse, then reassert.
        wait_c0(50);
        enable = 1'b0;
        tick();
        check_eq("enable_off_gates", 32'({hs_gate, ls_gate}), 32'd0);
        check_eq("enable_off_run", 32'(run), 32'd0);
        repeat (37) tick();
        enable = 1'b1;
        repeat (2 * P) tick();

        // Randomized operation against the model.
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(0, 299) == 0) enable = ~enable;
            if (!enable && $urandom_range(0, 99) == 0) enable = 1'b1;
            fault     = ($urandom_range(0, 1499) == 0);
            fault_clr = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 149) == 0) begin
                if ($urandom_range(0, 3) == 0) ict = 16'($urandom);
                else ict = 16'($urandom_range(0, 260));
            end
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
